// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle for add_pipe.
// The slave modport is the adder side, the master modport is the producer/consumer side.
interface add_pipe_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, mode, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, mode, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is resolved WIDTH/STAGES bits per stage,
// with valid bits travelling alongside the data and a single global advance for backpressure.
module add_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  add_pipe_if.slave  bus
);
  localparam int unsigned C = WIDTH / STAGES;

  typedef logic [WIDTH-1:0] word_t;

  logic  v_q     [STAGES];
  logic  v_d     [STAGES];
  word_t a_q     [STAGES];
  word_t a_d     [STAGES];
  word_t b_q     [STAGES];
  word_t b_d     [STAGES];
  word_t sum_q   [STAGES];
  word_t sum_d   [STAGES];
  logic  carry_q [STAGES];
  logic  carry_d [STAGES];
  logic  ovf_q;
  logic  ovf_d;

  word_t      a_src   [STAGES];
  word_t      b_src   [STAGES];
  word_t      s_src   [STAGES];
  logic       c_src   [STAGES];
  logic [C:0] chunk_c [STAGES];
  word_t      sum_nxt [STAGES];
  logic       advance_c;

  assign advance_c     = bus.out_ready || !v_q[STAGES-1];
  assign bus.in_ready  = advance_c;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.cout      = carry_q[STAGES-1];
  assign bus.ovf       = ovf_q;

  // Per-stage operands: stage 0 sees the live inputs, later stages see the previous register.
  always_comb begin
    a_src[0] = bus.a;
    b_src[0] = bus.mode ? ~bus.b : bus.b;
    c_src[0] = bus.mode | bus.cin;
    s_src[0] = '0;
    for (int k = 1; k < int'(STAGES); k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      c_src[k] = carry_q[k-1];
      s_src[k] = sum_q[k-1];
    end
    for (int k = 0; k < int'(STAGES); k++) begin
      chunk_c[k] = {1'b0, a_src[k][k*C +: C]} + {1'b0, b_src[k][k*C +: C]}
                 + (C+1)'(c_src[k]);
      sum_nxt[k] = s_src[k];
      sum_nxt[k][k*C +: C] = chunk_c[k][C-1:0];
    end
  end

  // Next state: everything holds unless the whole pipe advances.
  always_comb begin
    v_d     = v_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (advance_c) begin
      v_d[0] = bus.in_valid;
      for (int k = 1; k < int'(STAGES); k++) begin
        v_d[k] = v_q[k-1];
      end
      for (int k = 0; k < int'(STAGES); k++) begin
        a_d[k]     = a_src[k];
        b_d[k]     = b_src[k];
        carry_d[k] = chunk_c[k][C];
        sum_d[k]   = sum_nxt[k];
      end
      ovf_d = (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1])
           && (sum_nxt[STAGES-1][WIDTH-1] != a_src[STAGES-1][WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '{default: 1'b0};
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      sum_q   <= '{default: '0};
      carry_q <= '{default: 1'b0};
      ovf_q   <= 1'b0;
    end else begin
      v_q     <= v_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
